// File: rtl/npc_unit.sv
// Next-PC unit: fetch/decode PC registers, next fetch address selection, link address, branch counters.
// Optional BRANCH_LIKELY_EN annuls the delay slot of a not-taken branch-likely instruction.
module npc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  br_type,
   input  logic [1:0]  jump_type,
   input  logic        equal,
   input  logic        bez,
   input  logic        bgz,
   input  logic        blz,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] rs_data,
   input  logic        br_likely,
   output logic [31:0] pc_F,
   output logic [31:0] pc_D,
   output logic [31:0] link_D,
   output logic [31:0] npc,
   output logic        redirect,
   output logic        flush_D,
   output logic [31:0] br_cnt,
   output logic [31:0] taken_cnt
);

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_d_q, pc_d_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;

   logic        cond_taken;
   logic        is_branch;
   logic        is_jump;
   logic [31:0] pc_d_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;

   always_comb begin
      cond_taken = 1'b0;
      case (br_type)
         3'd1:    cond_taken = equal;
         3'd2:    cond_taken = ~equal;
         3'd3:    cond_taken = bez | blz;
         3'd4:    cond_taken = bgz;
         3'd5:    cond_taken = blz;
         3'd6:    cond_taken = bez | bgz;
         default: cond_taken = 1'b0;
      endcase
      is_branch  = (br_type != 3'd0) && (br_type != 3'd7);
      is_jump    = (jump_type == 2'd1) || (jump_type == 2'd2);
      pc_d_plus4 = pc_d_q + 32'd4;
      br_target  = pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      j_target   = {pc_d_plus4[31:28], instr_index, 2'b00};
   end

   // Jumps take priority over a simultaneously decoded branch (illegal decode).
   always_comb begin
      if (jump_type == 2'd2)
         npc = rs_data;
      else if (jump_type == 2'd1)
         npc = j_target;
      else if (cond_taken)
         npc = br_target;
      else
         npc = pc_f_q + 32'd4;
      redirect = is_jump | cond_taken;
   end

`ifdef BRANCH_LIKELY_EN
   assign flush_D = ~stall & br_likely & is_branch & ~cond_taken;
`else
   assign flush_D = 1'b0;
`endif

   always_comb begin
      pc_f_d      = pc_f_q;
      pc_d_d      = pc_d_q;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (!stall) begin
         pc_f_d = npc;
         pc_d_d = pc_f_q;
         // A jump paired with a branch suppresses the branch statistics.
         if (is_branch && !is_jump) begin
            br_cnt_d    = br_cnt_q + 32'd1;
            taken_cnt_d = taken_cnt_q + {31'd0, cond_taken};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f_q      <= RESET_PC;
         pc_d_q      <= RESET_PC - 32'd4;
         br_cnt_q    <= 32'd0;
         taken_cnt_q <= 32'd0;
      end else begin
         pc_f_q      <= pc_f_d;
         pc_d_q      <= pc_d_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc_F      = pc_f_q;
   assign pc_D      = pc_d_q;
   assign link_D    = pc_d_q + 32'd8;
   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: stimulus pushes expected per-cycle outputs from a reference model,
// a monitor pops and compares them mid-cycle.
module tb_npc_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset, stall, equal, bez, bgz, blz, br_likely;
   logic [2:0]  br_type;
   logic [1:0]  jump_type;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] rs_data;
   logic [31:0] pc_F, pc_D, link_D, npc, br_cnt, taken_cnt;
   logic        redirect, flush_D;

   npc_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_type(br_type), .jump_type(jump_type),
      .equal(equal), .bez(bez), .bgz(bgz), .blz(blz), .imm16(imm16),
      .instr_index(instr_index), .rs_data(rs_data), .br_likely(br_likely),
      .pc_F(pc_F), .pc_D(pc_D), .link_D(link_D), .npc(npc), .redirect(redirect),
      .flush_D(flush_D), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc_f, pc_d, link, npc, br, tk;
      logic        redir, flush;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle_no = 0;

   // Architectural reference state
   logic [31:0] m_pcf, m_pcd, m_br, m_tk;

   function automatic logic ref_taken(input logic [2:0] bt, input logic [31:0] rs, input logic [31:0] rt);
      logic signed [31:0] s;
      s = $signed(rs);
      case (bt)
         3'd1:    return rs == rt;
         3'd2:    return rs != rt;
         3'd3:    return s <= 0;
         3'd4:    return s > 0;
         3'd5:    return s < 0;
         3'd6:    return s >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic apply(input logic rst_i, input logic stall_i, input logic [2:0] bt,
                        input logic [1:0] jt, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic [25:0] idx, input logic lk);
      exp_t        e;
      logic        tk, jmp, br;
      logic [31:0] off;
      @(negedge clk);
      reset = rst_i; stall = stall_i; br_type = bt; jump_type = jt;
      equal = (rs == rt); bez = ($signed(rs) == 0); bgz = ($signed(rs) > 0); blz = ($signed(rs) < 0);
      imm16 = imm; instr_index = idx; rs_data = rs; br_likely = lk;
      if (rst_i) begin
         m_pcf = RST_PC; m_pcd = RST_PC - 4; m_br = 0; m_tk = 0;
      end
      tk  = ref_taken(bt, rs, rt);
      jmp = (jt == 2'd1) || (jt == 2'd2);
      br  = (bt >= 3'd1) && (bt <= 3'd6);
      off = {{16{imm[15]}}, imm};
      e.pc_f = m_pcf; e.pc_d = m_pcd; e.link = m_pcd + 8; e.br = m_br; e.tk = m_tk;
      if (jt == 2'd2)      e.npc = rs;
      else if (jt == 2'd1) e.npc = (((m_pcd + 4) >> 28) << 28) | ({6'd0, idx} << 2);
      else if (tk)         e.npc = m_pcd + 4 + off * 4;
      else                 e.npc = m_pcf + 4;
      e.redir = jmp || tk;
`ifdef BRANCH_LIKELY_EN
      e.flush = !stall_i && lk && br && !tk;
`else
      e.flush = 1'b0;
`endif
      exp_q.push_back(e);
      if (!rst_i && !stall_i) begin
         m_pcd = m_pcf;
         m_pcf = e.npc;
         if (br && !jmp) begin
            m_br = m_br + 1;
            if (tk) m_tk = m_tk + 1;
         end
      end
   endtask

   task automatic idle(input logic stall_i);
      apply(1'b0, stall_i, 3'd0, 2'd0, 32'd1, 32'd2, 16'd0, 26'd0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL cycle %0d %s: got 0x%08h expected 0x%08h", cycle_no, name, act, exp_v);
      end
   endtask

   // Monitor: mid-cycle, after inputs settle and before the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cycle_no++;
            chk("pc_F", pc_F, e.pc_f);
            chk("pc_D", pc_D, e.pc_d);
            chk("link_D", link_D, e.link);
            chk("npc", npc, e.npc);
            chk("br_cnt", br_cnt, e.br);
            chk("taken_cnt", taken_cnt, e.tk);
            chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
            chk("flush_D", {31'd0, flush_D}, {31'd0, e.flush});
            $display("cycle %0d pc_F=%08h pc_D=%08h npc=%08h redir=%0b flush=%0b br=%0d tk=%0d",
                     cycle_no, pc_F, pc_D, npc, redirect, flush_D, br_cnt, taken_cnt);
         end
      end
   end

   initial begin
      logic [31:0] rs, rt;
      int          drain;
      reset = 1'b1; stall = 1'b0; br_type = 3'd0; jump_type = 2'd0; equal = 1'b0;
      bez = 1'b0; bgz = 1'b0; blz = 1'b0; imm16 = 16'd0; instr_index = 26'd0;
      rs_data = 32'd0; br_likely = 1'b0;

      apply(1'b1, 1'b0, 3'd0, 2'd0, 32'd1, 32'd2, 16'd0, 26'd0, 1'b0);   // reset state
      idle(1'b0); idle(1'b0);                                              // pc_D = 0x3004
      apply(1'b0, 1'b0, 3'd1, 2'd0, 32'd5, 32'd5, 16'hFFFE, 26'd0, 1'b0); // BEQ back to 0x3000
      idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b0);
      repeat (3) apply(1'b0, 1'b1, 3'd4, 2'd0, 32'd0, 32'd7, 16'h0010, 26'd0, 1'b0); // stalled BGTZ
      apply(1'b0, 1'b0, 3'd4, 2'd0, 32'd0, 32'd7, 16'h0010, 26'd0, 1'b0);
      apply(1'b0, 1'b0, 3'd0, 2'd2, 32'h0040_0000, 32'd0, 16'd0, 26'd0, 1'b0); // JR 0x0040_0000
      idle(1'b0); idle(1'b0);
      apply(1'b0, 1'b1, 3'd0, 2'd1, 32'd0, 32'd0, 16'd0, 26'h0000100, 1'b0);   // J, stalled
      apply(1'b0, 1'b1, 3'd0, 2'd2, 32'h1234_5678, 32'd0, 16'd0, 26'd0, 1'b0);
      apply(1'b0, 1'b0, 3'd2, 2'd0, 32'd9, 32'd9, 16'h0004, 26'd0, 1'b1);      // BNE likely, not taken
      apply(1'b0, 1'b1, 3'd2, 2'd0, 32'd9, 32'd9, 16'h0004, 26'd0, 1'b1);      // same, stalled
      apply(1'b0, 1'b0, 3'd1, 2'd1, 32'd3, 32'd3, 16'h0008, 26'h3FF_FFFF, 1'b0); // jump wins, no count
      apply(1'b0, 1'b0, 3'd6, 2'd0, 32'hFFFF_FFFF, 32'd0, 16'h8000, 26'd0, 1'b0); // BGEZ not taken
      apply(1'b0, 1'b0, 3'd3, 2'd0, 32'h8000_0000, 32'd0, 16'h7FFF, 26'd0, 1'b0); // BLEZ taken
      apply(1'b1, 1'b1, 3'd1, 2'd0, 32'd1, 32'd1, 16'h0010, 26'd0, 1'b0);        // reset mid-branch
      idle(1'b0); idle(1'b0);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       rs = 32'd0;
            1:       rs = $urandom_range(0, 6) - 3;
            default: rs = $urandom;
         endcase
         rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
         apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0,
               rs, rt, 16'($urandom), 26'($urandom), 1'($urandom));
      end
      idle(1'b0);

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d items left, expected 0", exp_q.size());
      end
      #20;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
